alu_mdu_mips: RTL and testbench

//  Parametrised MIPS execute unit: single-cycle ALU plus an iterative multiply/divide unit (MDU)

---
 rtl/alu_mips_pkg.sv | 36 +++
 rtl/alu_mdu_mips_mdu_iter.sv | 147 ++++++++++++++
 rtl/alu_mdu_mips.sv | 148 ++++++++++++++
 tb/tb_alu_mdu_mips.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mips_pkg.sv
// Shared codes for the MIPS execute unit: ALU ops, MDU ops, FSM states.
// MDU_DIV_EN adds the DIV state; without it the divider is not built.
package alu_mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1011;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
  } state_t;
`endif

endpackage

// File: rtl/alu_mdu_mips_mdu_iter.sv
// Radix-2 multiply/divide datapath: operand latch, step, sign fix.
// MDU_DIV_EN adds the restoring-divide path and its state.
module mdu_iter
  import alu_mips_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIGN_FIX = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
`ifdef MDU_DIV_EN
  input  logic             op_div,
`endif
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] ONE  = SHW'(1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q, neg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] quo, rem;
`endif

  logic             sgn, sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;

  assign sgn    = (SIGN_FIX != 0) && op_signed;
  assign sa     = sgn && a[WIDTH-1];
  assign sb     = sgn && b[WIDTH-1];
  assign ma     = sa ? -a : a;
  assign mb     = sb ? -b : b;
  assign last   = run && (cnt_q == LAST);
  assign addend = q_q[0] ? m_q : '0;
  assign sum    = {1'b0, acc_q} + {1'b0, addend};

  // Latch magnitudes on load, then one shift-add/subtract per run cycle
  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    m_d   = m_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
`ifdef MDU_DIV_EN
    a_d    = a_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    div_d  = div_q;
    shl    = {acc_q, q_q[WIDTH-1]};
`endif
    if (load) begin
      acc_d = '0;
      q_d   = ma;
      m_d   = mb;
      neg_d = sa ^ sb;
      cnt_d = '0;
`ifdef MDU_DIV_EN
      a_d    = a;
      rneg_d = sa;
      dz_d   = (b == '0);
      div_d  = op_div;
`endif
    end else if (run) begin
      cnt_d = cnt_q + ONE;
`ifdef MDU_DIV_EN
      if (div_q) begin
        q_d   = {q_q[WIDTH-2:0], 1'b0};
        acc_d = shl[WIDTH-1:0];
        if (shl >= {1'b0, m_q}) begin
          acc_d  = shl[WIDTH-1:0] - m_q;
          q_d[0] = 1'b1;
        end
      end else
`endif
      begin
        acc_d = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
      end
    end
  end

  // Final result from the last step, sign-corrected
  always_comb begin
    prod = {acc_d, q_d};
    if (neg_q) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    quo = neg_q ? -q_d : q_d;
    rem = rneg_q ? -acc_d : acc_d;
    if (div_q) begin
      res_hi = dz_q ? a_q : rem;
      res_lo = dz_q ? '1 : quo;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      q_q   <= '0;
      m_q   <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
`ifdef MDU_DIV_EN
      a_q    <= '0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      div_q  <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      m_q   <= m_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
`ifdef MDU_DIV_EN
      a_q    <= a_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/alu_mdu_mips.sv
// MIPS EX unit: combinational ALU plus iterative MDU with HI/LO.
// MDU_DIV_EN enables div/divu; otherwise they complete as no-ops.
module alu_mdu_mips
  import alu_mips_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIGN_FIX = 1,
  localparam int SHW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] reg_data1,
  input  logic [WIDTH-1:0] reg_data2,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  input  logic             mdu_start,
  input  logic [2:0]       mdu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic op_mul, op_dv, op_sgn;
  logic accept, load, run, last;

  assign op_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign op_dv  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  assign op_sgn = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
  assign accept = (state_q == S_IDLE) && mdu_start;
  assign run    = (state_q != S_IDLE);

  // ALU result mux; unknown codes fall back to add
  always_comb begin
    alu_c = reg_data1 + reg_data2;
    unique case (1'b1)
      (control == ALU_SUB): alu_c = reg_data1 - reg_data2;
      (control == ALU_AND): alu_c = reg_data1 & reg_data2;
      (control == ALU_OR):  alu_c = reg_data1 | reg_data2;
      (control == ALU_XOR): alu_c = reg_data1 ^ reg_data2;
      (control == ALU_NOR): alu_c = ~(reg_data1 | reg_data2);
      (control == ALU_SLT):
        alu_c = {{(WIDTH-1){1'b0}},
                 $signed(reg_data1) < $signed(reg_data2)};
      (control == ALU_SLL): alu_c = reg_data2 << shamt;
      (control == ALU_SRL): alu_c = reg_data2 >> shamt;
      (control == ALU_SRA):
        alu_c = $signed(reg_data2) >>> shamt;
      default: alu_c = reg_data1 + reg_data2;
    endcase
  end

  assign aluout = alu_c;
  assign zero   = (alu_c == '0);

  mdu_iter #(
    .WIDTH   (WIDTH),
    .SIGN_FIX(SIGN_FIX)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .run      (run),
`ifdef MDU_DIV_EN
    .op_div   (op_dv),
`endif
    .op_signed(op_sgn),
    .a        (reg_data1),
    .b        (reg_data2),
    .last     (last),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave IDLE on an accepted mult/div
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && op_mul) state_d = S_MUL;
`ifdef MDU_DIV_EN
        if (accept && op_dv) state_d = S_DIV;
`endif
      end
      S_MUL: if (last) state_d = S_IDLE;
`ifdef MDU_DIV_EN
      S_DIV: if (last) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: datapath load, HI/LO writes and done pulse
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
`ifdef MDU_DIV_EN
    load = accept && (op_mul || op_dv);
    if (accept && !op_mul && !op_dv) begin
`else
    load = accept && op_mul;
    if (accept && !op_mul) begin
`endif
      done_d = 1'b1;
      if (mdu_op == OP_MTHI) hi_d = reg_data1;
      if (mdu_op == OP_MTLO) lo_d = reg_data1;
    end
    if (last) begin
      hi_d   = res_hi;
      lo_d   = res_lo;
      done_d = 1'b1;
    end
  end

  // HI/LO and done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign busy = run;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu_mips.sv
// Bench for alu_mdu_mips (WIDTH=32): reference model plus directed
// and random stimulus. Honours MDU_DIV_EN like the design.
module tb_alu_mdu_mips;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [3:0]  control;
  logic        start;
  logic [2:0]  op;
  logic [31:0] aluout, hi, lo;
  logic        zero, busy, done;

  int errors = 0;
  int checks = 0;

  alu_mdu_mips #(.WIDTH(W), .SIGN_FIX(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_data1(a),
    .reg_data2(b),
    .shamt    (shamt),
    .control  (control),
    .aluout   (aluout),
    .zero     (zero),
    .mdu_start(start),
    .mdu_op   (op),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] c,
      input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
    case (c)
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b1001: return x ^ y;
      4'b1011: return ~(x | y);
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1010: return y << s;
      4'b1100: return y >> s;
      4'b1101: return $signed(y) >>> s;
      default: return x + y;
    endcase
  endfunction

  // Returns {hi, lo}
  function automatic logic [63:0] mdu_ref(input logic [2:0] o,
      input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] px, py;
    logic signed [31:0] sq, sr;
    px = $signed(x);
    py = $signed(y);
    case (o)
      3'd0: return px * py;
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  int          m_cnt;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_hi = 0; m_lo = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end else if (start) begin
        case (op)
          3'd0, 3'd1: begin
            {p_hi, p_lo} = mdu_ref(op, a, b);
            m_cnt = W;
          end
          3'd2, 3'd3: begin
`ifdef MDU_DIV_EN
            {p_hi, p_lo} = mdu_ref(op, a, b);
            m_cnt = W;
`else
            m_done = 1;
`endif
          end
          3'd4: begin m_hi = a; m_done = 1; end
          3'd5: begin m_lo = a; m_done = 1; end
          default: m_done = 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] r;
    r = alu_ref(control, a, b, shamt);
    chk("aluout", aluout, r);
    chk("zero", {31'd0, zero}, {31'd0, r == 0});
    chk("busy", {31'd0, busy}, {31'd0, m_cnt > 0});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] e;
  } alu_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_vec_t vt[6];
    int cyc, nb, nd;
    vt[0] = '{4'b0010, 32'h12};
    vt[1] = '{4'b0110, 32'hC};
    vt[2] = '{4'b0000, 32'h3};
    vt[3] = '{4'b0001, 32'hF};
    vt[4] = '{4'b1001, 32'hC};
    vt[5] = '{4'b1011, 32'hFFFF_FFF0};

    rst_n = 1'b0; start = 1'b0; op = 3'd0;
    a = 0; b = 0; shamt = 0; control = 4'b0010;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    step();

    a = 32'hF; b = 32'h3;
    foreach (vt[i]) begin
      control = vt[i].c;
      #1 chk("alu_sweep", aluout, vt[i].e);
    end
    a = 32'hFFFF_FFFF; b = 32'd1; control = 4'b0111;
    #1 chk("slt", aluout, 32'd1);
    chk("slt_zero", {31'd0, zero}, 32'd0);
    b = 32'h8000_0000; shamt = 5'd4; control = 4'b1101;
    #1 chk("sra", aluout, 32'hF800_0000);
    step();

    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    nb = 0;
    while (busy && nb < 100) begin nb++; step(); end
    chk("mult_busy_cycles", nb, 32'd32);
    chk("mult_done", {31'd0, done}, 32'd1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

`ifdef MDU_DIV_EN
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd5, 32'd0);
    wait_done(cyc);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd5);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("divov_lo", lo, 32'h8000_0000);
    chk("divov_hi", hi, 32'd0);
`else
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("nodiv_done", {31'd0, done}, 32'd1);
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    chk("nodiv_hi", hi, 32'hFFFF_FFFE);
    chk("nodiv_lo", lo, 32'h0000_0001);
`endif
    step();

    issue(3'd0, 32'd100, 32'd3);
    repeat (9) step();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("ignored_hi", hi, 32'd0);
    chk("ignored_lo", lo, 32'd300);
    issue(3'd0, 32'd2, 32'd3);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(cyc);
    chk("b2b_lo", lo, 32'd6);

`ifdef MDU_DIV_EN
    issue(3'd2, 32'd1000, 32'd7);
`else
    issue(3'd0, 32'd1000, 32'd7);
`endif
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    step();
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin step(); if (done) nd++; end
    chk("arst_no_done", nd, 32'd0);
    issue(3'd0, 32'd5, 32'd6);
    wait_done(cyc);
    chk("arst_restart", lo, 32'd30);
    step();

    issue(3'd4, 32'hA5A5_A5A5, 32'd0);
    chk("mthi_done", {31'd0, done}, 32'd1);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    issue(3'd5, 32'h5A5A_5A5A, 32'd0);
    chk("mtlo_done", {31'd0, done}, 32'd1);
    chk("mtlo_lo", lo, 32'h5A5A_5A5A);
    issue(3'd6, 32'd1, 32'd1);
    chk("nop_done", {31'd0, done}, 32'd1);
    chk("nop_hi", hi, 32'hA5A5_A5A5);
    step();

    repeat (3000) begin
      case ($urandom_range(7))
        0: a = 32'h8000_0000;
        1: a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(15);
        default: b = $urandom;
      endcase
      control = 4'($urandom_range(15));
      shamt   = 5'($urandom_range(31));
      op      = 3'($urandom_range(7));
      start   = ($urandom_range(3) == 0);
      step();
    end
    start = 1'b0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
